// File: rtl/skew_feeder_pkg.sv
// skew_feeder_pkg: state type, counter width and drain-counter sizing shared by the skew feeder
package skew_feeder_pkg;

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_e;

    localparam int PerfCntWidth = 32;

    // Wide enough to hold NumLanes-2 plus headroom for NumLanes == 1.
    function automatic int drain_cnt_width(input int num_lanes);
        return $clog2(num_lanes) + 1;
    endfunction

endpackage

// File: rtl/skew_lane.sv
// skew_lane: Depth-stage delay line carrying {valid, data}, async active-low clear
//   clk_i, rst_ni     clock, async active-low reset
//   valid_i, data_i   stage-0 input
//   valid_o, data_o   output of the last stage (Depth cycles later)
module skew_lane #(
    parameter int Depth     = 1,
    parameter int DataWidth = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 valid_i,
    input  logic [DataWidth-1:0] data_i,
    output logic                 valid_o,
    output logic [DataWidth-1:0] data_o
);

    logic [Depth-1:0]     valid_q;
    logic [DataWidth-1:0] data_q [Depth];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            for (int i = 0; i < Depth; i++) data_q[i] <= '0;
        end else begin
            valid_q[0] <= valid_i;
            data_q[0]  <= data_i;
            for (int i = 1; i < Depth; i++) begin
                valid_q[i] <= valid_q[i-1];
                data_q[i]  <= data_q[i-1];
            end
        end
    end

    assign valid_o = valid_q[Depth-1];
    assign data_o  = data_q[Depth-1];

endmodule

// File: rtl/skew_feeder.sv
// skew_feeder: diagonal-skew input feeder for a systolic array edge
//   clk_i, rst_ni              clock, async active-low reset
//   in_data_i/valid/last/ready beat input handshake (lane l = bits [l*DataWidth +: DataWidth])
//   out_data_o, out_valid_o    lane l delayed l cycles relative to lane 0
//   busy_o                     tile in flight or pipeline non-empty
//   done_o                     one-cycle pulse when the last beat leaves the last lane
//   beat_cnt_o, bubble_cnt_o   saturating perf counters, only with SKEW_FEEDER_PERF_EN defined
module skew_feeder
    import skew_feeder_pkg::*;
#(
    parameter int NumLanes  = 4,
    parameter int DataWidth = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NumLanes*DataWidth-1:0] in_data_i,
    input  logic                          in_valid_i,
    input  logic                          in_last_i,
    output logic                          in_ready_o,
    output logic [NumLanes*DataWidth-1:0] out_data_o,
    output logic [NumLanes-1:0]           out_valid_o,
    output logic                          busy_o,
`ifdef SKEW_FEEDER_PERF_EN
    output logic                          done_o,
    output logic [PerfCntWidth-1:0]       beat_cnt_o,
    output logic [PerfCntWidth-1:0]       bubble_cnt_o
`else
    output logic                          done_o
`endif
);

    localparam int                CntW      = drain_cnt_width(NumLanes);
    localparam logic [CntW-1:0]   DrainLoad = CntW'(NumLanes > 1 ? NumLanes - 2 : 0);

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [NumLanes-1:0]  last_q;
    logic                 accept;

    assign in_ready_o = (state_q != DRAIN);
    assign accept     = in_valid_i & in_ready_o;
    assign busy_o     = (state_q != IDLE) | (|out_valid_o);
    assign done_o     = last_q[NumLanes-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (accept) begin
            state_d = in_last_i ? ((NumLanes == 1) ? IDLE : DRAIN) : STREAM;
            cnt_d   = DrainLoad;
        end else if (state_q == DRAIN) begin
            state_d = (cnt_q == '0) ? IDLE : DRAIN;
            cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
        end
    end

    // The last flag rides a shadow delay line as deep as the final lane, so
    // done_o lines up with the last beat on out_valid_o[NumLanes-1].
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q[0] <= accept & in_last_i;
            for (int i = 1; i < NumLanes; i++) last_q[i] <= last_q[i-1];
        end
    end

    // Non-accept cycles inject zero data so invalid lanes always read 0.
    for (genvar l = 0; l < NumLanes; l++) begin : g_lane
        skew_lane #(
            .Depth     (l + 1),
            .DataWidth (DataWidth)
        ) u_lane (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .valid_i (accept),
            .data_i  (accept ? in_data_i[l*DataWidth +: DataWidth] : '0),
            .valid_o (out_valid_o[l]),
            .data_o  (out_data_o[l*DataWidth +: DataWidth])
        );
    end

`ifdef SKEW_FEEDER_PERF_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            beat_cnt_o   <= '0;
            bubble_cnt_o <= '0;
        end else begin
            if (accept && beat_cnt_o != '1) beat_cnt_o <= beat_cnt_o + 1'b1;
            if (state_q == STREAM && !in_valid_i && bubble_cnt_o != '1) bubble_cnt_o <= bubble_cnt_o + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_skew_feeder.sv
// tb_skew_feeder: directed stimulus with a history-based reference model for skew_feeder
module tb_skew_feeder;

    localparam int N  = 4;
    localparam int DW = 8;

    logic            clk = 0;
    logic            rst_n = 0;
    logic [N*DW-1:0] in_data = '0;
    logic            in_valid = 0;
    logic            in_last = 0;
    logic            in_ready;
    logic [N*DW-1:0] out_data;
    logic [N-1:0]    out_valid;
    logic            busy;
    logic            done;
`ifdef SKEW_FEEDER_PERF_EN
    logic [31:0]     beat_cnt;
    logic [31:0]     bubble_cnt;
`endif

    int checks = 0;
    int errors = 0;

    skew_feeder #(.NumLanes(N), .DataWidth(DW)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .in_data_i    (in_data),
        .in_valid_i   (in_valid),
        .in_last_i    (in_last),
        .in_ready_o   (in_ready),
        .out_data_o   (out_data),
        .out_valid_o  (out_valid),
        .busy_o       (busy),
`ifdef SKEW_FEEDER_PERF_EN
        .done_o       (done),
        .beat_cnt_o   (beat_cnt),
        .bubble_cnt_o (bubble_cnt)
`else
        .done_o       (done)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what was injected at each past edge (newest first).
    // A lane l output shows what was injected l edges ago.
    typedef struct {
        bit              v;
        bit              l;
        logic [N*DW-1:0] d;
    } inj_t;

    inj_t hist[$];
    int   drain_left;
    bit   tile_open;
    int   exp_beats;
    int   exp_bubbles;

    always @(posedge clk or negedge rst_n) begin : model
        bit   acc;
        inj_t e;
        if (!rst_n) begin
            hist.delete();
            drain_left  = 0;
            tile_open   = 0;
            exp_beats   = 0;
            exp_bubbles = 0;
        end else begin
            acc = in_valid && (drain_left == 0);
            e.v = acc;
            e.l = acc && in_last;
            e.d = acc ? in_data : '0;
            if (tile_open && !in_valid) exp_bubbles++;
            if (acc) exp_beats++;
            if (drain_left > 0) drain_left--;
            if (acc && in_last) begin
                drain_left = N - 1;
                tile_open  = 0;
            end else if (acc) tile_open = 1;
            hist.push_front(e);
            if (hist.size() > N) void'(hist.pop_back());
        end
    end

    always @(negedge clk) begin : compare
        logic [N*DW-1:0] ed;
        logic [N-1:0]    ev;
        bit              edone;
        if (rst_n) begin
            ed = '0;
            ev = '0;
            for (int l = 0; l < N; l++)
                if (hist.size() > l && hist[l].v) begin
                    ev[l]           = 1'b1;
                    ed[l*DW +: DW]  = hist[l].d[l*DW +: DW];
                end
            edone = (hist.size() > N - 1) && hist[N-1].l;
            chk("out_valid", 64'(out_valid), 64'(ev));
            chk("out_data",  64'(out_data),  64'(ed));
            chk("done",      64'(done),      64'(edone));
            chk("in_ready",  64'(in_ready),  64'(drain_left == 0));
            chk("busy",      64'(busy),      64'(tile_open || drain_left > 0 || ev != 0));
`ifdef SKEW_FEEDER_PERF_EN
            chk("beat_cnt",   64'(beat_cnt),   64'(exp_beats));
            chk("bubble_cnt", 64'(bubble_cnt), 64'(exp_bubbles));
`endif
        end
    end

    task automatic drive(input logic v, input logic [N*DW-1:0] d, input logic l);
        @(negedge clk);
        in_valid = v;
        in_data  = d;
        in_last  = l;
    endtask

    task automatic idle_until_quiet();
        int n;
        drive(0, '0, 0);
        n = 0;
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("quiet_timeout", 64'(busy), 64'(0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 rst_n = 0;
        #1;
        chk("rst_valid", 64'(out_valid), 64'(0));
        chk("rst_data",  64'(out_data),  64'(0));
        chk("rst_done",  64'(done),      64'(0));
        @(negedge clk);
        #1 rst_n = 1;
        chk("rst_ready", 64'(in_ready), 64'(1));
        chk("rst_busy",  64'(busy),     64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_valid", 64'(out_valid), 64'(0));
        chk("reset_data",  64'(out_data),  64'(0));
        chk("reset_busy",  64'(busy),      64'(0));
        chk("reset_done",  64'(done),      64'(0));
        #1 rst_n = 1;

        // 1: single-beat tile
        drive(1, 32'h04030201, 1);
        drive(0, '0, 0);
        chk("t1_c1_data", 64'(out_data), 64'h00000001);
        chk("t1_c1_ready", 64'(in_ready), 64'(0));
        @(negedge clk);
        chk("t1_c2_data", 64'(out_data), 64'h00000200);
        @(negedge clk);
        chk("t1_c3_data", 64'(out_data), 64'h00030000);
        chk("t1_c3_ready", 64'(in_ready), 64'(0));
        @(negedge clk);
        chk("t1_c4_data", 64'(out_data),  64'h04000000);
        chk("t1_c4_valid", 64'(out_valid), 64'h8);
        chk("t1_c4_done", 64'(done),      64'(1));
        chk("t1_c4_ready", 64'(in_ready), 64'(1));
        @(negedge clk);
        chk("t1_c5_done", 64'(done), 64'(0));
        chk("t1_c5_busy", 64'(busy), 64'(0));

        // 2: five back-to-back beats
        for (int i = 0; i < 5; i++) drive(1, {N{8'(8'h10 + i)}}, i == 4);
        drive(0, '0, 0);
        chk("t2_diag", 64'(out_data), 64'h11121314);
        chk("t2_diag_valid", 64'(out_valid), 64'hF);
        idle_until_quiet();

        // 3: one valid gap inside STREAM
        do_reset();
        drive(1, {N{8'h20}}, 0);
        drive(1, {N{8'h21}}, 0);
        drive(0, '0, 0);
        drive(1, {N{8'h22}}, 1);
        drive(0, '0, 0);
        chk("t3_gap_lane1", 64'(out_data[15:8]), 64'h00);
        chk("t3_gap_valid", 64'(out_valid), 64'b1101);
        idle_until_quiet();
`ifdef SKEW_FEEDER_PERF_EN
        chk("t3_beats",   64'(beat_cnt),   64'd3);
        chk("t3_bubbles", 64'(bubble_cnt), 64'd1);
`endif

        // 4: valid held through DRAIN
        drive(1, {N{8'h30}}, 1);
        drive(1, {N{8'h31}}, 1);
        repeat (4) @(negedge clk);
        chk("t4_next_lane0", 64'(out_data[7:0]), 64'h31);
        chk("t4_next_valid0", 64'(out_valid[0]), 64'(1));
        idle_until_quiet();

        // 5: reset mid-STREAM
        drive(1, {N{8'h40}}, 0);
        drive(1, {N{8'h41}}, 0);
        drive(0, '0, 0);
        do_reset();
        repeat (6) @(negedge clk);
        chk("t5_no_done", 64'(done), 64'(0));

        // 6: in_last without in_valid is ignored
        drive(0, '0, 1);
        @(negedge clk);
        chk("t6_idle_busy", 64'(busy), 64'(0));
        drive(1, {N{8'h50}}, 0);
        drive(0, '0, 1);
        chk("t6_stream_busy", 64'(busy), 64'(1));
        drive(1, {N{8'h51}}, 0);
        drive(0, '0, 1);
        @(negedge clk);
        chk("t6_still_ready", 64'(in_ready), 64'(1));
        drive(1, {N{8'h52}}, 1);
        idle_until_quiet();

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
